relu_bwd_unit: RTL and testbench



---
 rtl/relu_bwd_unit.sv | 146 ++++++++++++++
 tb/tb_relu_bwd_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_bwd_unit.sv
// ReLU backward gate: records forward positivity bits in a mask FIFO and gates dA into dZ.
// Optional zero-gradient statistics counter enabled by defining RELU_BWD_STATS_EN.
module relu_bwd_unit #(
   parameter int dataWidth = 32,
   parameter int DEPTH     = 64,
   parameter int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 z_valid,
   input  logic [dataWidth-1:0] z,
   output logic                 z_ready,
   input  logic                 da_valid,
   input  logic [dataWidth-1:0] da,
   output logic                 da_ready,
   output logic                 dz_valid,
   output logic [dataWidth-1:0] dz,
   input  logic                 dz_ready,
   output logic [CNT_W-1:0]     mask_count
`ifdef RELU_BWD_STATS_EN
   ,
   output logic [31:0]          zero_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   // +0.0, -0.0, negatives and NaN all map to 0; +Inf maps to 1.
   function automatic logic is_positive(input logic [31:0] v);
      logic is_nan;
      is_nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
      return (v[31] == 1'b0) && (v[30:0] != 31'd0) && !is_nan;
   endfunction

   logic [DEPTH-1:0]     mem_q, mem_d;
   logic [PTR_W-1:0]     wptr_q, wptr_d;
   logic [PTR_W-1:0]     rptr_q, rptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 dz_valid_q, dz_valid_d;
   logic [dataWidth-1:0] dz_q, dz_d;
   logic                 full_s, empty_s;
   logic                 z_ready_s, da_ready_s;
   logic                 wr_en_s, rd_en_s;
   logic                 head_bit_s;

   assign full_s     = (cnt_q == CNT_W'(DEPTH));
   assign empty_s    = (cnt_q == {CNT_W{1'b0}});
   assign z_ready_s  = !full_s;
   assign da_ready_s = !empty_s && (!dz_valid_q || dz_ready);
   assign wr_en_s    = z_valid && z_ready_s && !flush;
   assign rd_en_s    = da_valid && da_ready_s && !flush;
   assign head_bit_s = mem_q[rptr_q];

   // Next-state for mask storage, pointers, occupancy and output stage.
   always_comb begin
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      cnt_d      = cnt_q;
      dz_valid_d = dz_valid_q;
      dz_d       = dz_q;
      if (flush) begin
         wptr_d     = {PTR_W{1'b0}};
         rptr_d     = {PTR_W{1'b0}};
         cnt_d      = {CNT_W{1'b0}};
         dz_valid_d = 1'b0;
         dz_d       = {dataWidth{1'b0}};
      end else begin
         if (wr_en_s) begin
            mem_d[wptr_q] = is_positive(z);
            wptr_d        = wptr_q + PTR_W'(1);
         end else begin
            wptr_d = wptr_q;
         end
         // A same-cycle read sees the old head, so a fresh write is never bypassed.
         if (rd_en_s) begin
            rptr_d     = rptr_q + PTR_W'(1);
            dz_d       = head_bit_s ? da : {dataWidth{1'b0}};
            dz_valid_d = 1'b1;
         end else if (dz_ready) begin
            dz_valid_d = 1'b0;
         end else begin
            dz_valid_d = dz_valid_q;
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q      <= {DEPTH{1'b0}};
         wptr_q     <= {PTR_W{1'b0}};
         rptr_q     <= {PTR_W{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         dz_valid_q <= 1'b0;
         dz_q       <= {dataWidth{1'b0}};
      end else begin
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         dz_valid_q <= dz_valid_d;
         dz_q       <= dz_d;
      end
   end

   assign z_ready    = z_ready_s;
   assign da_ready   = da_ready_s;
   assign dz_valid   = dz_valid_q;
   assign dz         = dz_q;
   assign mask_count = cnt_q;

`ifdef RELU_BWD_STATS_EN
   logic [31:0] zero_count_q, zero_count_d;

   // Saturating count of gradients forced to zero.
   always_comb begin
      zero_count_d = zero_count_q;
      if (flush) begin
         zero_count_d = 32'd0;
      end else if (rd_en_s && !head_bit_s && (zero_count_q != 32'hFFFF_FFFF)) begin
         zero_count_d = zero_count_q + 32'd1;
      end else begin
         zero_count_d = zero_count_q;
      end
   end

   // Statistics register.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_count_q <= 32'd0;
      end else begin
         zero_count_q <= zero_count_d;
      end
   end

   assign zero_count = zero_count_q;
`endif

endmodule

// File: tb/tb_relu_bwd_unit.sv
// Directed self-checking bench for relu_bwd_unit (DEPTH=64).
module tb_relu_bwd_unit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        z_valid;
   logic [31:0] z;
   logic        z_ready;
   logic        da_valid;
   logic [31:0] da;
   logic        da_ready;
   logic        dz_valid;
   logic [31:0] dz;
   logic        dz_ready;
   logic [6:0]  mask_count;
`ifdef RELU_BWD_STATS_EN
   logic [31:0] zero_count;
`endif

   int tests_run;
   int tests_failed;

   relu_bwd_unit #(.dataWidth(32), .DEPTH(64)) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .z_valid(z_valid),
      .z(z),
      .z_ready(z_ready),
      .da_valid(da_valid),
      .da(da),
      .da_ready(da_ready),
      .dz_valid(dz_valid),
      .dz(dz),
      .dz_ready(dz_ready),
      .mask_count(mask_count)
`ifdef RELU_BWD_STATS_EN
      ,
      .zero_count(zero_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] zv [6];
   logic [31:0] dzexp [6];
   int          max_cnt;
   logic [31:0] exp_v;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst      = 1'b1;
      flush    = 1'b0;
      z_valid  = 1'b0;
      z        = 32'h0;
      da_valid = 1'b0;
      da       = 32'h0;
      dz_ready = 1'b1;
      step();
      step();
      check_eq("rst_z_ready", 32'(z_ready), 32'd1);
      check_eq("rst_da_ready", 32'(da_ready), 32'd0);
      check_eq("rst_dz_valid", 32'(dz_valid), 32'd0);
      check_eq("rst_dz", dz, 32'h0);
      check_eq("rst_count", 32'(mask_count), 32'd0);
      rst = 1'b0;
      step();

      // Special float classes
      zv[0] = 32'h3F800000; dzexp[0] = 32'h40400000;
      zv[1] = 32'h80000000; dzexp[1] = 32'h00000000;
      zv[2] = 32'hC0000000; dzexp[2] = 32'h00000000;
      zv[3] = 32'h7F800000; dzexp[3] = 32'h40400000;
      zv[4] = 32'h7FC00000; dzexp[4] = 32'h00000000;
      zv[5] = 32'h00000000; dzexp[5] = 32'h00000000;
      for (int i = 0; i < 6; i++) begin
         z_valid = 1'b1;
         z       = zv[i];
         step();
      end
      z_valid = 1'b0;
      check_eq("cls_count6", 32'(mask_count), 32'd6);
      for (int i = 0; i < 6; i++) begin
         da_valid = 1'b1;
         da       = 32'h40400000;
         check_eq("cls_da_ready", 32'(da_ready), 32'd1);
         step();
         check_eq("cls_dz_valid", 32'(dz_valid), 32'd1);
         check_eq("cls_dz", dz, dzexp[i]);
      end
      da_valid = 1'b0;
      step();
      check_eq("cls_dz_valid_clr", 32'(dz_valid), 32'd0);
      check_eq("cls_count0", 32'(mask_count), 32'd0);
`ifdef RELU_BWD_STATS_EN
      check_eq("cls_zero_count", zero_count, 32'd4);
`endif

      // Fill to full, held 65th, then read-only and read+write
      z_valid = 1'b1;
      z       = 32'h3F800000;
      for (int i = 0; i < 64; i++) step();
      z = 32'hC0000000;
      check_eq("full_count", 32'(mask_count), 32'd64);
      check_eq("full_z_ready", 32'(z_ready), 32'd0);
      step();
      step();
      check_eq("full_hold_count", 32'(mask_count), 32'd64);
      da_valid = 1'b1;
      da       = 32'h41000000;
      step();
      check_eq("full_rd_count", 32'(mask_count), 32'd63);
      check_eq("full_rd_dz", dz, 32'h41000000);
      step();
      check_eq("full_rw_count", 32'(mask_count), 32'd63);
      check_eq("full_rw_dz", dz, 32'h41000000);
      z_valid = 1'b0;
      for (int i = 0; i < 63; i++) begin
         da = 32'h41000000 + 32'(i);
         step();
         exp_v = (i < 62) ? (32'h41000000 + 32'(i)) : 32'h0;
         check_eq("drain_dz", dz, exp_v);
      end
      da_valid = 1'b0;
      step();
      check_eq("drain_count", 32'(mask_count), 32'd0);
      check_eq("drain_dz_valid", 32'(dz_valid), 32'd0);

      // Backpressure
      z_valid = 1'b1;
      z       = 32'h3F800000;
      step();
      z = 32'h40000000;
      step();
      z_valid  = 1'b0;
      dz_ready = 1'b0;
      da_valid = 1'b1;
      da       = 32'hBF000000;
      step();
      check_eq("bp_first_dz", dz, 32'hBF000000);
      da = 32'h40A00000;
      for (int k = 0; k < 5; k++) begin
         check_eq("bp_da_ready", 32'(da_ready), 32'd0);
         step();
         check_eq("bp_dz_hold", dz, 32'hBF000000);
         check_eq("bp_valid_hold", 32'(dz_valid), 32'd1);
         check_eq("bp_count", 32'(mask_count), 32'd1);
      end
      dz_ready = 1'b1;
      #1;
      check_eq("bp_release_ready", 32'(da_ready), 32'd1);
      step();
      check_eq("bp_release_dz", dz, 32'h40A00000);
      check_eq("bp_release_count", 32'(mask_count), 32'd0);
      da_valid = 1'b0;
      step();
      check_eq("bp_idle_valid", 32'(dz_valid), 32'd0);

      // Streaming across pointer wrap
      max_cnt = 0;
      for (int i = 0; i <= 200; i++) begin
         z_valid  = (i < 200);
         z        = (i % 2 == 0) ? 32'h3F800000 : 32'hBF800000;
         da_valid = (i > 0);
         da       = 32'h40000000 + 32'(i);
         step();
         if (int'(mask_count) > max_cnt) max_cnt = int'(mask_count);
         if (i > 0) begin
            exp_v = ((i - 1) % 2 == 0) ? (32'h40000000 + 32'(i)) : 32'h0;
            check_eq("wrap_dz", dz, exp_v);
         end
      end
      z_valid  = 1'b0;
      da_valid = 1'b0;
      check_eq("wrap_max_le2", 32'(max_cnt <= 2), 32'd1);
      step();
      check_eq("wrap_count", 32'(mask_count), 32'd0);

      // Flush with pending output and same-cycle write/read
      z_valid = 1'b1;
      z       = 32'h3F800000;
      for (int i = 0; i < 11; i++) step();
      z_valid  = 1'b0;
      dz_ready = 1'b0;
      da_valid = 1'b1;
      da       = 32'h3F000000;
      step();
      da_valid = 1'b0;
      check_eq("pre_flush_count", 32'(mask_count), 32'd10);
      check_eq("pre_flush_valid", 32'(dz_valid), 32'd1);
      flush    = 1'b1;
      z_valid  = 1'b1;
      da_valid = 1'b1;
      step();
      flush    = 1'b0;
      z_valid  = 1'b0;
      da_valid = 1'b0;
      check_eq("flush_count", 32'(mask_count), 32'd0);
      check_eq("flush_dz_valid", 32'(dz_valid), 32'd0);
      check_eq("flush_dz", dz, 32'h0);
      check_eq("flush_da_ready", 32'(da_ready), 32'd0);
      check_eq("flush_z_ready", 32'(z_ready), 32'd1);
`ifdef RELU_BWD_STATS_EN
      check_eq("flush_zero_count", zero_count, 32'd0);
`endif

      // Write into empty is not readable in the same cycle
      dz_ready = 1'b1;
      z_valid  = 1'b1;
      z        = 32'h3F800000;
      da_valid = 1'b1;
      da       = 32'h12345678;
      #1;
      check_eq("empty_da_ready", 32'(da_ready), 32'd0);
      step();
      z_valid = 1'b0;
      check_eq("empty_no_bypass", 32'(dz_valid), 32'd0);
      check_eq("empty_count1", 32'(mask_count), 32'd1);
      step();
      da_valid = 1'b0;
      check_eq("empty_late_dz", dz, 32'h12345678);
      check_eq("empty_late_count", 32'(mask_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
